rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the 2 write ports of the 4R2W integer register file among NREQ write-back
//  sources (ALU0, ALU1, LSU, MUL/DIV). Uses rotating priority with at most 2 grants/cycle.
//  Never issues two same-cycle writes to one register. Absorbs x0 writes without using a port.
//  Sits between the execute/write-back stage and the register file's w_addr/w_data/w_en inputs.
// PARAMETERS
//  DATA_WIDTH  32  width of register data
//  NREQ        4   number of write-back requesters (2..8)
// PORTS
//  clk          in   1                 core clock
//  rst_n        in   1                 asynchronous, active-low reset
//  req_valid_i  in   NREQ              requester i has a write pending
//  req_addr_i   in   NREQ x 5          destination register of requester i
//  req_data_i   in   NREQ x DATA_WIDTH write data of requester i
//  req_ready_o  out  NREQ              request i is accepted this cycle (valid && ready)
//  w_en_o       out  2                 register-file write enable, ports 0/1
//  w_addr_o     out  2 x 5             register-file write address, ports 0/1
//  w_data_o     out  2 x DATA_WIDTH    register-file write data, ports 0/1
//  rr_ptr_o     out  $clog2(NREQ)      current priority pointer (debug/perf)
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n). Reset clears:
//    w_en_o=0, w_addr_o=0, w_data_o=0, rr_ptr=0.
//  - Requester protocol: valid/addr/data are held stable until ready.
//    Valid must not depend on ready. req_ready_o is combinational from the current-cycle inputs.
//  - Scan order per cycle: i = rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
//  - Valid requests with addr==0 are always ready. They are dropped, use no port and do not
//    advance rr_ptr.
//  - The first valid nonzero-address request in scan order gets slot 0.
//  - The next valid nonzero-address request whose addr differs from slot 0's gets slot 1.
//    Any later request with an equal addr is skipped (ready=0) and retries next cycle.
//  - Grants beyond 2 get ready=0. No request is ever dropped except x0 writes.
//  - Latency: an accepted request appears on w_*_o the next cycle (registered outputs).
//    It is committed by the register file at the following edge.
//  - Slot k registers {1, addr, data} into port k. An unused slot drives w_en_o[k]=0.
//    Its addr/data hold the previous value.
//  - rr_ptr update: (index of last granted nonzero request + 1) mod NREQ. Unchanged if no grant.
//    This bounds the wait of any held request to ceil(NREQ/2) busy cycles.
//  - Ordering: same-register writes from different requesters commit in grant order.
//    Same-cycle same-register conflicts are impossible by construction.
//  - Data width: pure muxing, no arithmetic. rr_ptr wraps at NREQ-1 -> 0, including NREQ not
//    a power of two.
//  - Reset mid-operation: in-flight output writes are cancelled asynchronously (w_en_o=0).
//    Requests are not remembered.
//  - All requesters idle: w_en_o=0 next cycle; rr_ptr holds.
// STRUCTURE
//  - Shared package (core_pkg):
//    - typedef wb_req_t {logic [4:0] addr; logic [DATA_WIDTH-1:0] data;}
//    - localparam RF_WPORTS=2
//    - localparam RF_ADDR_W=5
//  - Sub-module wb_rr_pick2: combinational rotate-scan picker.
//    - Inputs: valid mask, addrs, rr_ptr.
//    - Outputs: two one-hot grants with found flags, and the ready vector.
//  - Top: instantiates wb_rr_pick2 and holds the output-stage flops and rr_ptr.
// TESTING
//  - Reset: assert rst_n=0 mid-stream with w_en_o=2'b11 -> w_en_o=0 immediately, rr_ptr_o=0.
//  - Grant order: rr_ptr=0; req0 r3=A, req1 r5=B, req2 r7=C.
//    -> ready=0011; next cycle port0={r3,A}, port1={r5,B}; rr_ptr=2.
//    Next cycle, C is granted on port0 alone.
//  - Same-address: req0 and req1 both r9 (0x11, 0x22); req2 r4.
//    -> grants req0 (port0) and req2 (port1); req1 stalls.
//    Next cycle req1 commits r9=0x22 after 0x11.
//  - x0 drop: req1 addr 0 plus req2 r6.
//    -> ready=0110; only w_en_o=01 with r6; rr_ptr=3.
//  - Fairness: all 4 requesters valid and held for 4 cycles.
//    -> each is granted exactly twice, in order 0,1 | 2,3 | 0,1 | 2,3.
//  - Wrap: NREQ=3, rr_ptr=2, all valid.
//    -> grants 2 (port0) and 0 (port1); rr_ptr=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared register-file write-back definitions used by the arbiter and its picker.
package core_pkg;

  localparam int RF_WPORTS = 2;
  localparam int RF_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational rotate-scan picker: up to two grants per cycle, never two to one register.
module wb_rr_pick2
  import core_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                valid,
  input  logic [NREQ-1:0][RF_ADDR_W-1:0] addr,
  input  logic [$clog2(NREQ)-1:0]        rr_ptr,
  output logic [NREQ-1:0]                gnt0,
  output logic                           found0,
  output logic [NREQ-1:0]                gnt1,
  output logic                           found1,
  output logic [NREQ-1:0]                ready
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W:0]         sum;
  logic [PTR_W-1:0]       idx;
  logic [RF_ADDR_W-1:0]   slot0_addr;

  always_comb begin
    gnt0       = '0;
    gnt1       = '0;
    found0     = 1'b0;
    found1     = 1'b0;
    ready      = '0;
    slot0_addr = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
      idx = sum[PTR_W-1:0];
      if (valid[idx]) begin
        // x0 writes are absorbed here: accepted without consuming a port
        if (addr[idx] == '0) begin
          ready[idx] = 1'b1;
        end else if (!found0) begin
          gnt0[idx]  = 1'b1;
          found0     = 1'b1;
          slot0_addr = addr[idx];
          ready[idx] = 1'b1;
        end else if (!found1 && (addr[idx] != slot0_addr)) begin
          gnt1[idx]  = 1'b1;
          found1     = 1'b1;
          ready[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the two register-file write ports among NREQ sources
// with rotating priority and registered port outputs.
module rf_wb_arbiter
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NREQ-1:0]                       req_valid_i,
  input  logic [NREQ-1:0][RF_ADDR_W-1:0]        req_addr_i,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]       req_data_i,
  output logic [NREQ-1:0]                       req_ready_o,
  output logic [RF_WPORTS-1:0]                  w_en_o,
  output logic [RF_WPORTS-1:0][RF_ADDR_W-1:0]   w_addr_o,
  output logic [RF_WPORTS-1:0][DATA_WIDTH-1:0]  w_data_o,
  output logic [$clog2(NREQ)-1:0]               rr_ptr_o
);

  localparam int PTR_W = $clog2(NREQ);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NREQ-1)) ? '0 : p + 1'b1;
  endfunction

  logic [NREQ-1:0]                       gnt0_p0, gnt1_p0;
  logic                                  found0_p0, found1_p0;
  logic [RF_ADDR_W-1:0]                  slot0_addr_p0, slot1_addr_p0;
  logic [DATA_WIDTH-1:0]                 slot0_data_p0, slot1_data_p0;
  logic [PTR_W-1:0]                      last_idx_p0;
  logic [PTR_W-1:0]                      rr_ptr;
  logic [RF_WPORTS-1:0]                  vld_p1;
  logic [RF_WPORTS-1:0][RF_ADDR_W-1:0]   w_addr_p1;
  logic [RF_WPORTS-1:0][DATA_WIDTH-1:0]  w_data_p1;

  wb_rr_pick2 #(.NREQ(NREQ)) u_pick (
    .valid  (req_valid_i),
    .addr   (req_addr_i),
    .rr_ptr (rr_ptr),
    .gnt0   (gnt0_p0),
    .found0 (found0_p0),
    .gnt1   (gnt1_p0),
    .found1 (found1_p0),
    .ready  (req_ready_o)
  );

  // Stage p0: one-hot select of slot payloads and the last granted index
  always_comb begin
    slot0_addr_p0 = '0;
    slot0_data_p0 = '0;
    slot1_addr_p0 = '0;
    slot1_data_p0 = '0;
    last_idx_p0   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt0_p0[i]) begin
        slot0_addr_p0 = req_addr_i[i];
        slot0_data_p0 = req_data_i[i];
      end
      if (gnt1_p0[i]) begin
        slot1_addr_p0 = req_addr_i[i];
        slot1_data_p0 = req_data_i[i];
      end
      if (found1_p0 ? gnt1_p0[i] : gnt0_p0[i]) last_idx_p0 = PTR_W'(i);
    end
  end

  // Stage p1: registered write ports and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= '0;
      w_addr_p1 <= '0;
      w_data_p1 <= '0;
      rr_ptr    <= '0;
    end else begin
      vld_p1 <= {found1_p0, found0_p0};
      if (found0_p0) begin
        w_addr_p1[0] <= slot0_addr_p0;
        w_data_p1[0] <= slot0_data_p0;
        rr_ptr       <= ptr_inc(last_idx_p0);
      end
      if (found1_p0) begin
        w_addr_p1[1] <= slot1_addr_p0;
        w_data_p1[1] <= slot1_data_p0;
      end
    end
  end

  assign w_en_o   = vld_p1;
  assign w_addr_o = w_addr_p1;
  assign w_data_o = w_data_p1;
  assign rr_ptr_o = rr_ptr;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: 4-requester instance plus a 3-requester wrap instance.
module tb_rf_wb_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]           valid;
  logic [3:0][4:0]      addr;
  logic [3:0][DW-1:0]   data;
  logic [3:0]           ready;
  logic [1:0]           w_en;
  logic [1:0][4:0]      w_addr;
  logic [1:0][DW-1:0]   w_data;
  logic [1:0]           rr_ptr;

  logic [2:0]           valid3;
  logic [2:0][4:0]      addr3;
  logic [2:0][DW-1:0]   data3;
  logic [2:0]           ready3;
  logic [1:0]           w_en3;
  logic [1:0][4:0]      w_addr3;
  logic [1:0][DW-1:0]   w_data3;
  logic [1:0]           rr_ptr3;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt[4];

  rf_wb_arbiter #(.DATA_WIDTH(DW), .NREQ(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data), .req_ready_o(ready),
    .w_en_o(w_en), .w_addr_o(w_addr), .w_data_o(w_data), .rr_ptr_o(rr_ptr)
  );

  rf_wb_arbiter #(.DATA_WIDTH(DW), .NREQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(valid3), .req_addr_i(addr3), .req_data_i(data3), .req_ready_o(ready3),
    .w_en_o(w_en3), .w_addr_o(w_addr3), .w_data_o(w_data3), .rr_ptr_o(rr_ptr3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = '0; addr  = '0; data  = '0;
    valid3 = '0; addr3 = '0; data3 = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    #12;
    chk("rst_wen",  w_en,   2'b00);
    chk("rst_ptr",  rr_ptr, 2'd0);
    chk("rst_addr", w_addr, '0);
    chk("rst_data", w_data, '0);
    rst_n = 1'b1;
    tick();

    // grant order from rr_ptr=0
    valid = 4'b0111;
    addr[0] = 5'd3; data[0] = 32'hA0A0_0003;
    addr[1] = 5'd5; data[1] = 32'hB0B0_0005;
    addr[2] = 5'd7; data[2] = 32'hC0C0_0007;
    #1 chk("go_ready", ready, 4'b0011);
    tick();
    chk("go_wen",   w_en,      2'b11);
    chk("go_a0",    w_addr[0], 5'd3);
    chk("go_d0",    w_data[0], 32'hA0A0_0003);
    chk("go_a1",    w_addr[1], 5'd5);
    chk("go_d1",    w_data[1], 32'hB0B0_0005);
    chk("go_ptr",   rr_ptr,    2'd2);
    valid = 4'b0100;
    #1 chk("go2_ready", ready, 4'b0100);
    tick();
    chk("go2_wen",  w_en,      2'b01);
    chk("go2_a0",   w_addr[0], 5'd7);
    chk("go2_d0",   w_data[0], 32'hC0C0_0007);
    chk("go2_a1h",  w_addr[1], 5'd5);
    chk("go2_ptr",  rr_ptr,    2'd3);

    // idle
    valid = 4'b0000;
    #1 chk("idle_ready", ready, 4'b0000);
    tick();
    chk("idle_wen", w_en,      2'b00);
    chk("idle_ptr", rr_ptr,    2'd3);
    chk("idle_a0h", w_addr[0], 5'd7);

    // same-address conflict, rr_ptr=3
    valid = 4'b0111;
    addr[0] = 5'd9; data[0] = 32'h11;
    addr[1] = 5'd9; data[1] = 32'h22;
    addr[2] = 5'd4; data[2] = 32'h44;
    #1 chk("sa_ready", ready, 4'b0101);
    tick();
    chk("sa_wen",  w_en,      2'b11);
    chk("sa_a0",   w_addr[0], 5'd9);
    chk("sa_d0",   w_data[0], 32'h11);
    chk("sa_a1",   w_addr[1], 5'd4);
    chk("sa_d1",   w_data[1], 32'h44);
    chk("sa_ptr",  rr_ptr,    2'd3);
    valid = 4'b0010;
    #1 chk("sa2_ready", ready, 4'b0010);
    tick();
    chk("sa2_wen", w_en,      2'b01);
    chk("sa2_a0",  w_addr[0], 5'd9);
    chk("sa2_d0",  w_data[0], 32'h22);
    chk("sa2_ptr", rr_ptr,    2'd2);

    // x0 drop alongside a real write, rr_ptr=2
    valid = 4'b0110;
    addr[1] = 5'd0; data[1] = 32'hDEAD;
    addr[2] = 5'd6; data[2] = 32'h66;
    #1 chk("x0_ready", ready, 4'b0110);
    tick();
    chk("x0_wen", w_en,      2'b01);
    chk("x0_a0",  w_addr[0], 5'd6);
    chk("x0_d0",  w_data[0], 32'h66);
    chk("x0_ptr", rr_ptr,    2'd3);
    valid = 4'b0010;
    #1 chk("x0only_ready", ready, 4'b0010);
    tick();
    chk("x0only_wen", w_en,   2'b00);
    chk("x0only_ptr", rr_ptr, 2'd3);

    // fill both ports, then reset mid-cycle
    valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 5'(i + 1);
      data[i] = 32'h100 + i;
    end
    #1 chk("pre_rst_ready", ready, 4'b1001);
    tick();
    chk("pre_rst_wen", w_en,      2'b11);
    chk("pre_rst_a0",  w_addr[0], 5'd4);
    chk("pre_rst_a1",  w_addr[1], 5'd1);
    chk("pre_rst_ptr", rr_ptr,    2'd1);
    valid = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", w_en,   2'b00);
    chk("mid_rst_ptr", rr_ptr, 2'd0);
    #1 rst_n = 1'b1;
    tick();

    // fairness: all four held for four cycles
    valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1 chk("fair_ready", ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      for (int i = 0; i < 4; i++) if (ready[i]) cnt[i]++;
      tick();
      chk("fair_wen", w_en,      2'b11);
      chk("fair_a0",  w_addr[0], (c % 2 == 0) ? 5'd1 : 5'd3);
      chk("fair_a1",  w_addr[1], (c % 2 == 0) ? 5'd2 : 5'd4);
      chk("fair_ptr", rr_ptr,    (c % 2 == 0) ? 2'd2 : 2'd0);
    end
    for (int i = 0; i < 4; i++) chk("fair_count", 64'(cnt[i]), 64'd2);
    valid = 4'b0000;

    // NREQ=3 wrap: move pointer to 2 first
    valid3 = 3'b010;
    addr3[1] = 5'd1; data3[1] = 32'h301;
    #1 chk("w3_ready0", ready3, 3'b010);
    tick();
    chk("w3_ptr0", rr_ptr3, 2'd2);
    valid3 = 3'b111;
    addr3[0] = 5'd10; data3[0] = 32'h310;
    addr3[1] = 5'd11; data3[1] = 32'h311;
    addr3[2] = 5'd12; data3[2] = 32'h312;
    #1 chk("w3_ready1", ready3, 3'b101);
    tick();
    chk("w3_wen1", w_en3,      2'b11);
    chk("w3_a0",   w_addr3[0], 5'd12);
    chk("w3_a1",   w_addr3[1], 5'd10);
    chk("w3_d1",   w_data3[1], 32'h310);
    chk("w3_ptr1", rr_ptr3,    2'd1);
    valid3 = 3'b110;
    addr3[2] = 5'd13; data3[2] = 32'h313;
    #1 chk("w3_ready2", ready3, 3'b110);
    tick();
    chk("w3_a0b",  w_addr3[0], 5'd11);
    chk("w3_a1b",  w_addr3[1], 5'd13);
    chk("w3_ptr2", rr_ptr3,    2'd0);
    valid3 = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
